// File: rtl/sram_write_ctrl.sv
// sram_write_ctrl: sequences decoder pixel writes and full-frame clears onto a shared, granted SRAM write port
// Ports: i_clk, i_rst (sync, active-high); i_pixel_data, i_col_addr {XS,XE}, i_row_addr {YS,YE} from the decoder;
//   i_clr_req, i_write_req, i_waddr_set_req are level-stretched requests, edge detected here;
//   o_sram_addr, o_sram_wdata, o_sram_we with i_sram_ack form the granted write port;
//   o_busy reports pending work, o_overflow is a sticky dropped-pixel flag.
module sram_write_ctrl #(
  parameter int H_PIXELS   = 160,
  parameter int V_PIXELS   = 128,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [15:0]       i_pixel_data,
  input  logic [31:0]       i_col_addr,
  input  logic [31:0]       i_row_addr,
  input  logic              i_clr_req,
  input  logic              i_write_req,
  input  logic              i_waddr_set_req,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [15:0]       o_sram_wdata,
  output logic              o_sram_we,
  input  logic              i_sram_ack,
  output logic              o_busy,
  output logic              o_overflow
);
  localparam int CW = $clog2(H_PIXELS);
  localparam int RW = $clog2(V_PIXELS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_W + 16;
  localparam logic [1:0] IDLE = 2'd0, WRITE = 2'd1, CLEAR = 2'd2;
  localparam logic [15:0] XMAX = 16'(H_PIXELS - 1);
  localparam logic [15:0] YMAX = 16'(V_PIXELS - 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(H_PIXELS * V_PIXELS - 1);

  logic [1:0] state_q, state_d;
  logic we_q, we_d, ovf_q, ovf_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [CW-1:0] xs_q, xs_d, xe_q, xe_d, cx_q, cx_d;
  logic [RW-1:0] ys_q, ys_d, ye_q, ye_d, cy_q, cy_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PW:0] cnt_q, cnt_d;
  logic [2:0] req_q, req_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] mem_d [FIFO_DEPTH];

  logic clr_ev, wr_ev, set_ev;
  logic [15:0] xs_c, xe_m, xe_c, ys_c, ye_m, ye_c;
  logic [CW-1:0] exs, exe, ecx, nx;
  logic [RW-1:0] eys, eye, ecy, ny;
  logic [ADDR_W-1:0] waddr;
  logic [EW-1:0] entry, nxt;
  logic pop, full, try_push, push, drop;

  assign req_d  = {i_clr_req, i_write_req, i_waddr_set_req};
  assign clr_ev = req_d[2] & ~req_q[2];
  assign wr_ev  = req_d[1] & ~req_q[1];
  assign set_ev = req_d[0] & ~req_q[0];

  // Clip starts and ends to the frame, then widen an inverted window to a single column/row.
  assign xs_c = i_col_addr[31:16] > XMAX ? XMAX : i_col_addr[31:16];
  assign xe_m = i_col_addr[15:0] > XMAX ? XMAX : i_col_addr[15:0];
  assign xe_c = xs_c > xe_m ? xs_c : xe_m;
  assign ys_c = i_row_addr[31:16] > YMAX ? YMAX : i_row_addr[31:16];
  assign ye_m = i_row_addr[15:0] > YMAX ? YMAX : i_row_addr[15:0];
  assign ye_c = ys_c > ye_m ? ys_c : ye_m;

  // A window set in the same cycle as a write takes effect before the pixel is placed.
  assign exs = set_ev ? CW'(xs_c) : xs_q;
  assign exe = set_ev ? CW'(xe_c) : xe_q;
  assign eys = set_ev ? RW'(ys_c) : ys_q;
  assign eye = set_ev ? RW'(ye_c) : ye_q;
  assign ecx = set_ev ? CW'(xs_c) : cx_q;
  assign ecy = set_ev ? RW'(ys_c) : cy_q;
  assign nx  = ecx == exe ? exs : ecx + CW'(1);
  assign ny  = ecx != exe ? ecy : ecy == eye ? eys : ecy + RW'(1);

  assign waddr = ADDR_W'(32'(ecy) * 32'(H_PIXELS) + 32'(ecx));
  assign entry = {waddr, i_pixel_data};

  // The presented word stays in the FIFO until granted, so it counts toward fullness.
  assign pop      = state_q == WRITE && i_sram_ack;
  assign full     = cnt_q[PW];
  assign try_push = wr_ev && state_q != CLEAR;
  assign push     = try_push && (!full || pop);
  assign drop     = try_push && full && !pop;
  // With one entry left, the follow-on word can only be the one arriving this cycle.
  assign nxt      = |cnt_q[PW:1] ? mem_q[rd_q + PW'(1)] : entry;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ovf_d   = ovf_q | drop;
    xs_d    = exs;
    xe_d    = exe;
    ys_d    = eys;
    ye_d    = eye;
    cx_d    = push ? nx : ecx;
    cy_d    = push ? ny : ecy;
    rd_d    = pop ? rd_q + PW'(1) : rd_q;
    wr_d    = push ? wr_q + PW'(1) : wr_q;
    cnt_d   = cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    mem_d   = mem_q;
    if (push) mem_d[wr_q] = entry;
    if (state_q == IDLE && |cnt_q) begin
      state_d           = WRITE;
      we_d              = 1'b1;
      {addr_d, wdata_d} = mem_q[rd_q];
    end else if (pop) begin
      state_d = |cnt_d ? WRITE : IDLE;
      we_d    = |cnt_d;
      if (|cnt_d) {addr_d, wdata_d} = nxt;
    end else if (state_q == CLEAR && i_sram_ack) begin
      state_d = addr_q == LAST ? IDLE : CLEAR;
      we_d    = addr_q != LAST;
      addr_d  = addr_q + ADDR_W'(1);
    end
    if (clr_ev) begin
      state_d = CLEAR;
      we_d    = 1'b1;
      addr_d  = '0;
      wdata_d = '0;
      ovf_d   = 1'b0;
      xs_d    = '0;
      xe_d    = CW'(H_PIXELS - 1);
      ys_d    = '0;
      ye_d    = RW'(V_PIXELS - 1);
      cx_d    = '0;
      cy_d    = '0;
      rd_d    = '0;
      wr_d    = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ovf_q   <= 1'b0;
      xs_q    <= '0;
      xe_q    <= CW'(H_PIXELS - 1);
      ys_q    <= '0;
      ye_q    <= RW'(V_PIXELS - 1);
      cx_q    <= '0;
      cy_q    <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ovf_q   <= ovf_d;
      xs_q    <= xs_d;
      xe_q    <= xe_d;
      ys_q    <= ys_d;
      ye_q    <= ye_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  always_ff @(posedge i_clk) mem_q <= mem_d;

  assign o_sram_addr  = addr_q;
  assign o_sram_wdata = wdata_q;
  assign o_sram_we    = we_q;
  assign o_overflow   = ovf_q;
  assign o_busy       = state_q == CLEAR || |cnt_q || we_q;
endmodule
